// File: rtl/fp_normalizer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fp_normalizer_seq
// Description : Post-add normalization stage of the single-precision adder.
//               Shifts the raw mantissa sum back into 1.f form one bit per
//               cycle, adjusts the exponent, then packs {sign, exp, frac}
//               with overflow/underflow flags behind a valid/ready handshake.
//               Optional macro FP_NORM_ROUND_EN: round half to even on
//               right shifts (guard bit only, no sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalizer_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [MANT_W+1:0]         in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     out_result,
    output logic                      out_overflow,
    output logic                      out_underflow
);

    localparam int SUM_W = MANT_W + 2;

    localparam logic [EXP_W-1:0] c_EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] c_EXP_TOP  = c_EXP_ONES - EXP_W'(1);
    localparam logic [EXP_W-1:0] c_EXP_ONE  = EXP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_sign;
    logic [EXP_W-1:0]        r_exp;
    logic [SUM_W-1:0]        r_mant;
    logic [EXP_W+MANT_W:0]   r_result;
    logic                    r_ovf;
    logic                    r_unf;

    state_t                  w_state_nxt;
    logic                    w_sign_nxt;
    logic [EXP_W-1:0]        w_exp_nxt;
    logic [SUM_W-1:0]        w_mant_nxt;
    logic [EXP_W+MANT_W:0]   w_result_nxt;
    logic                    w_ovf_nxt;
    logic                    w_unf_nxt;

    logic                    w_accept;
    logic [SUM_W-1:0]        w_shr;
    logic [SUM_W-1:0]        w_shr_rnd;
    logic                    w_carry;
    logic                    w_hidden;

    assign in_ready      = (r_state == S_IDLE) && !rst;
    assign w_accept      = in_valid && in_ready;
    assign out_valid     = (r_state == S_DONE);
    assign out_result    = r_result;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;

    assign w_carry  = r_mant[MANT_W+1];
    assign w_hidden = r_mant[MANT_W];
    assign w_shr    = {1'b0, r_mant[SUM_W-1:1]};

`ifdef FP_NORM_ROUND_EN
    // Dropped bit acts as guard; ties go to even. A resulting carry is
    // handled by another right shift on the following edge.
    assign w_shr_rnd = w_shr + SUM_W'(r_mant[0] & w_shr[0]);
`else
    // Right shifts simply truncate the dropped bit.
    assign w_shr_rnd = w_shr;
`endif

    // Next-state and datapath update: one normalization action per edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_sign_nxt   = r_sign;
        w_exp_nxt    = r_exp;
        w_mant_nxt   = r_mant;
        w_result_nxt = r_result;
        w_ovf_nxt    = r_ovf;
        w_unf_nxt    = r_unf;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_sign_nxt = in_sign;
                    w_exp_nxt  = in_exp;
                    w_mant_nxt = in_mant;
                    if (in_exp == c_EXP_ONES) begin
                        // Incoming infinity/NaN exponent saturates at once.
                        w_result_nxt = {in_sign, c_EXP_ONES, {MANT_W{1'b0}}};
                        w_ovf_nxt    = 1'b1;
                        w_unf_nxt    = 1'b0;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_state_nxt = S_NORM;
                    end
                end
            end

            S_NORM: begin
                if (r_mant == '0) begin
                    w_result_nxt = {r_sign, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = 1'b0;
                    w_state_nxt  = S_DONE;
                end else if (w_carry && (r_exp == c_EXP_TOP)) begin
                    w_result_nxt = {r_sign, c_EXP_ONES, {MANT_W{1'b0}}};
                    w_ovf_nxt    = 1'b1;
                    w_unf_nxt    = 1'b0;
                    w_state_nxt  = S_DONE;
                end else if (w_carry) begin
                    w_mant_nxt = w_shr_rnd;
                    w_exp_nxt  = r_exp + c_EXP_ONE;
                end else if (!w_hidden && (r_exp <= c_EXP_ONE)) begin
                    // Exponent exhausted before reaching 1.f: flush to zero
                    // (the <= also keeps a zero exponent from wrapping).
                    w_result_nxt = {r_sign, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = 1'b1;
                    w_state_nxt  = S_DONE;
                end else if (!w_hidden) begin
                    w_mant_nxt = {r_mant[SUM_W-2:0], 1'b0};
                    w_exp_nxt  = r_exp - c_EXP_ONE;
                end else begin
                    w_result_nxt = {r_sign, r_exp, r_mant[MANT_W-1:0]};
                    w_ovf_nxt    = 1'b0;
                    w_unf_nxt    = 1'b0;
                    w_state_nxt  = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sign   <= w_sign_nxt;
            r_exp    <= w_exp_nxt;
            r_mant   <= w_mant_nxt;
            r_result <= w_result_nxt;
            r_ovf    <= w_ovf_nxt;
            r_unf    <= w_unf_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_normalizer_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalizer_seq
// Description : Self-checking bench for fp_normalizer_seq. Directed vectors,
//               handshake/reset scenarios and random operands compared with
//               an arithmetic reference model (leading-one search).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalizer_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int checks = 0;
    int errors = 0;

    fp_normalizer_seq #(.EXP_W(8), .MANT_W(23)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: locate the leading one and derive the result directly.
    task automatic model(input logic s, input logic [7:0] e, input logic [24:0] m,
                         output logic [31:0] r, output logic ov, output logic un,
                         output int lat);
        int p;
        int ee;
        int k;
        logic [25:0] mm;
        ov = 1'b0; un = 1'b0; lat = 1;
        r = {s, 31'd0};
        if (e == 8'hFF) begin
            r = {s, 8'hFF, 23'd0}; ov = 1'b1; return;
        end
        if (m == 25'd0) return;
        p = -1;
        for (int i = 0; i < 25; i++) if (m[i]) p = i;
        ee = int'(e);
        mm = {1'b0, m};
        if (p == 24) begin
            if (ee == 254) begin
                r = {s, 8'hFF, 23'd0}; ov = 1'b1; return;
            end
            mm = mm >> 1;
`ifdef FP_NORM_ROUND_EN
            if (m[0] && mm[0]) mm = mm + 26'd1;
`endif
            ee = ee + 1; lat = 2;
            if (mm[24]) begin
                if (ee == 254) begin
                    r = {s, 8'hFF, 23'd0}; ov = 1'b1; lat = 2; return;
                end
                mm = mm >> 1; ee = ee + 1; lat = 3;
            end
        end else if (p < 23) begin
            k = 23 - p;
            if (ee <= k) begin
                un = 1'b1; lat = ee; return;
            end
            mm = mm << k; ee = ee - k; lat = k + 1;
        end
        r = {s, 8'(ee), mm[22:0]};
    endtask

    // Issue one operation, measure latency from accept edge, then accept it.
    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                          output logic [31:0] r, output logic ov, output logic un,
                          output int lat, output bit to);
        int w;
        to = 1'b0; lat = 0; w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sign = 1'($urandom); in_exp = 8'($urandom); in_mant = 25'($urandom);
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        if (!out_valid) to = 1'b1;
        r = out_result; ov = out_overflow; un = out_underflow;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = 8'd0; in_mant = 25'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_result, out_overflow, out_underflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b res=%h ov=%b un=%b, want all 0",
                     in_ready, out_valid, out_result, out_overflow, out_underflow);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [24:0] vm [6];
        logic [7:0]  ve [6];
        logic        vs [6];
        logic [31:0] wr [6];
        logic        wo [6];
        logic        wu [6];
        int          wl [6];
        logic [31:0] r, mr;
        logic ov, un, mov, mun;
        int lat, mlat;
        bit to;
        ve[0] = 8'h80; vm[0] = 25'h0C00000; vs[0] = 0; wr[0] = 32'h40400000; wo[0] = 0; wu[0] = 0; wl[0] = 1;
        ve[1] = 8'h7F; vm[1] = 25'h1000000; vs[1] = 0; wr[1] = 32'h40000000; wo[1] = 0; wu[1] = 0; wl[1] = 2;
        ve[2] = 8'h85; vm[2] = 25'h0010000; vs[2] = 0; wr[2] = 32'h3F000000; wo[2] = 0; wu[2] = 0; wl[2] = 8;
        ve[3] = 8'h01; vm[3] = 25'h0400000; vs[3] = 0; wr[3] = 32'h00000000; wo[3] = 0; wu[3] = 1; wl[3] = 1;
        ve[4] = 8'hFE; vm[4] = 25'h1000000; vs[4] = 0; wr[4] = 32'h7F800000; wo[4] = 1; wu[4] = 0; wl[4] = 1;
        ve[5] = 8'h42; vm[5] = 25'h0000000; vs[5] = 1; wr[5] = 32'h80000000; wo[5] = 0; wu[5] = 0; wl[5] = 1;
        for (int i = 0; i < 6; i++) begin
            run_op(vs[i], ve[i], vm[i], r, ov, un, lat, to);
            checks++;
            if (to || r !== wr[i] || ov !== wo[i] || un !== wu[i] || lat != wl[i]) begin
                errors++;
                $display("FAIL directed_%0d: got res=%h ov=%b un=%b lat=%0d to=%b, want res=%h ov=%b un=%b lat=%0d",
                         i, r, ov, un, lat, to, wr[i], wo[i], wu[i], wl[i]);
            end
        end
        // Rounding vector: expectation depends on the build option.
        run_op(1'b0, 8'h7F, 25'h1000003, r, ov, un, lat, to);
        model(1'b0, 8'h7F, 25'h1000003, mr, mov, mun, mlat);
        checks++;
`ifdef FP_NORM_ROUND_EN
        if (to || r !== 32'h40000002 || mr !== 32'h40000002) begin
`else
        if (to || r !== 32'h40000001 || mr !== 32'h40000001) begin
`endif
            errors++;
            $display("FAIL round_vector: got %h (model %h)", r, mr);
        end
        // Exponent all-ones saturates regardless of mantissa.
        run_op(1'b1, 8'hFF, 25'h0ABCDEF, r, ov, un, lat, to);
        checks++;
        if (to || r !== 32'hFF800000 || ov !== 1'b1 || un !== 1'b0 || lat > 1) begin
            errors++;
            $display("FAIL exp_all_ones: got res=%h ov=%b un=%b lat=%0d, want FF800000 ov=1 un=0 lat<=1",
                     r, ov, un, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        bit bad;
        int w;
        bad = 1'b0; w = 0;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h85; in_mant = 25'h0010000;
        @(posedge clk); #1;
        // Keep presenting a different operand while busy; it must be ignored.
        in_exp = 8'h10; in_mant = 25'h1FFFFFF; in_sign = 1'b0;
        while (!out_valid && w < 60) begin @(posedge clk); #1; w++; end
        held = out_result;
        checks++;
        if (!out_valid || held !== 32'hBF000000) begin
            errors++;
            $display("FAIL bp_result: got v=%b res=%h want v=1 res=BF000000", out_valid, held);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!out_valid || out_result !== held || in_ready !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: got v=%b res=%h rdy=%b, want v=1 res=%h rdy=0",
                     out_valid, out_result, in_ready, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic ov, un;
        int lat;
        bit to, seen;
        seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0000001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 32'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got v=%b rdy=%b res=%h want 0 0 0",
                     out_valid, in_ready, out_result);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_abort: got v_seen=%b rdy=%b want 0 1", seen, in_ready);
        end
        run_op(1'b0, 8'h80, 25'h0C00000, r, ov, un, lat, to);
        checks++;
        if (to || r !== 32'h40400000 || ov || un || lat != 1) begin
            errors++;
            $display("FAIL midrst_recover: got res=%h lat=%0d want 40400000 lat=1", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        int vcycles;
        int w;
        vcycles = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            w = 0;
            while (!in_ready && w < 50) begin @(negedge clk); w++; end
            in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h1000000;
            @(negedge clk);
            in_valid = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (out_valid) vcycles++;
            end
        end
        out_ready = 1'b0;
        checks++;
        if (vcycles != 2) begin
            errors++;
            $display("FAIL b2b_done_width: got %0d valid cycles want 2", vcycles);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, mr;
        logic ov, un, mov, mun;
        int lat, mlat, p;
        bit to;
        logic s;
        logic [7:0] e;
        logic [24:0] m;
        for (int n = 0; n < 80; n++) begin
            s = 1'($urandom);
            e = 8'($urandom_range(1, 254));
            if (n % 10 == 0) e = 8'($urandom_range(1, 24));
            if (n % 17 == 0) e = 8'hFE;
            p = int'($urandom_range(0, 25));
            if (p == 25) m = 25'd0;
            else m = (25'($urandom) & ((25'd1 << p) - 25'd1)) | (25'd1 << p);
            if (n % 13 == 0) m = 25'h1FFFFFF;
            model(s, e, m, mr, mov, mun, mlat);
            run_op(s, e, m, r, ov, un, lat, to);
            checks++;
            if (to || r !== mr || ov !== mov || un !== mun || lat != mlat) begin
                errors++;
                $display("FAIL random_%0d e=%h m=%h: got res=%h ov=%b un=%b lat=%0d, want res=%h ov=%b un=%b lat=%0d",
                         n, e, m, r, ov, un, lat, mr, mov, mun, mlat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
